rtc_bus_write_sequencer: RTL and testbench

//  Parametrised multiplexed-bus (Intel-mode, DS12887-class) RTC write sequencer; successor to the fixed 9-register writer.
//  On start, walks a table of NUM_REGS address/data pairs, skips masked entries and drives one bus write cycle per entry.
//  Per-entry edit override (user-entered values replace live values); optional trailing command byte; completion handshake.

---
 rtl/rtc_bus_write_sequencer_if.sv | 22 ++
 rtl/rtc_bus_write_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rtc_bus_write_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_write_sequencer_if.sv
// Handshake and multiplexed RTC pin bundle for the bus write sequencer.
// master drives start and observes the bus; slave is the sequencer.
interface rtc_bus_write_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [3:0]            cur_index;
  logic [3:0]            control;
  logic [DATA_WIDTH-1:0] AD;

  modport master (
    output start,
    input  busy, done, cur_index, control, AD
  );

  modport slave (
    input  start,
    output busy, done, cur_index, control, AD
  );
endinterface

// File: rtl/rtc_bus_write_sequencer.sv
// Intel-mode multiplexed-bus RTC write sequencer: walks an address/data table, one bus write per enabled entry.
// Optional RTC_UPDATE_INHIBIT_EN wraps the sequence in SET=1 / SET=0 writes to register 0x0B.
//
// state   | meaning
// S_IDLE  | waiting for start, bus parked
// S_ADDR  | CS_n low, AS high, address on AD
// S_LATCH | AS falls, address held one cycle
// S_GAP   | AD released before write strobe
// S_WRITE | WR_n low, data on AD
// S_REC   | bus parked, recovery before next write
// S_FIN   | done pulse, back to idle
module rtc_bus_write_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 9,
  parameter int T_ADDR     = 8,
  parameter int T_GAP      = 2,
  parameter int T_WR       = 8,
  parameter int T_REC      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS-1:0]            reg_en,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] addr_flat,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] data_flat,
  input  logic [NUM_REGS-1:0]            edit_mask,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] edit_flat,
  input  logic                           cmd_en,
  input  logic [DATA_WIDTH-1:0]          cmd_addr,
  input  logic [DATA_WIDTH-1:0]          cmd_data,
  rtc_bus_write_sequencer_if.slave       bus
);

`ifdef RTC_UPDATE_INHIBIT_EN
  localparam bit INHIBIT = 1'b1;
`else
  localparam bit INHIBIT = 1'b0;
`endif

  localparam int T_MAX_AG = (T_ADDR > T_GAP) ? T_ADDR : T_GAP;
  localparam int T_MAX_WR = (T_WR > T_REC) ? T_WR : T_REC;
  localparam int T_MAX    = (T_MAX_AG > T_MAX_WR) ? T_MAX_AG : T_MAX_WR;
  localparam int CNT_W    = $clog2(T_MAX) + 1;

  localparam logic [3:0] CTRL_PARK  = 4'b1011;
  localparam logic [3:0] CTRL_ADDR  = 4'b0111;
  localparam logic [3:0] CTRL_HOLD  = 4'b0011;
  localparam logic [3:0] CTRL_WRITE = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_GAP, S_WRITE, S_REC, S_FIN
  } state_t;

  // Kind of write in flight; K_NONE also means "coming from idle" / "nothing left".
  typedef enum logic [2:0] {
    K_NONE, K_PRE, K_ENTRY, K_CMD, K_POST
  } kind_t;

  state_t state, state_d;
  kind_t  kind_q, from_kind, nxt_kind;

  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  tc;
  int                    phase_len;
  logic                  load, go;

  logic [NUM_REGS-1:0]   en_q, edm_q, mask_src, edm_src;
  logic                  cmd_q, cmd_src;
  logic [4:0]            idx_q, base, found_idx;
  logic                  seek, found;
  logic [DATA_WIDTH-1:0] addr_q, data_q;
  logic [DATA_WIDTH-1:0] sel_addr, sel_data, ent_addr, ent_data;
  logic [3:0]            sel_index;

  logic [3:0]            control_q, control_d;
  logic [DATA_WIDTH-1:0] ad_q, ad_d;
  logic                  busy_q, done_q;
  logic [3:0]            cur_index_q;

  logic [DATA_WIDTH-1:0] addr_arr [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REGS];
  logic [DATA_WIDTH-1:0] edit_arr [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign addr_arr[g] = addr_flat[g*DATA_WIDTH +: DATA_WIDTH];
    assign data_arr[g] = data_flat[g*DATA_WIDTH +: DATA_WIDTH];
    assign edit_arr[g] = edit_flat[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    phase_len = 1;
    unique case (state)
      S_ADDR:  phase_len = T_ADDR;
      S_GAP:   phase_len = T_GAP;
      S_WRITE: phase_len = T_WR;
      S_REC:   phase_len = T_REC;
      default: phase_len = 1;
    endcase
    tc = (cnt == CNT_W'(phase_len - 1));
  end

  // Next-write selection; at start the live inputs are used since latches load on the same edge.
  always_comb begin
    from_kind = (state == S_IDLE) ? K_NONE : kind_q;
    seek      = 1'b0;
    base      = '0;
    mask_src  = en_q;
    edm_src   = edm_q;
    cmd_src   = cmd_q;
    unique case (from_kind)
      K_NONE: begin
        seek     = !INHIBIT;
        mask_src = reg_en;
        edm_src  = edit_mask;
        cmd_src  = cmd_en;
      end
      K_PRE:   seek = 1'b1;
      K_ENTRY: begin
        seek = 1'b1;
        base = idx_q + 5'd1;
      end
      default: seek = 1'b0;
    endcase

    found     = 1'b0;
    found_idx = '0;
    ent_addr  = '0;
    ent_data  = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (seek && mask_src[i] && (i >= int'(base))) begin
        found     = 1'b1;
        found_idx = 5'(i);
        ent_addr  = addr_arr[i];
        ent_data  = edm_src[i] ? edit_arr[i] : data_arr[i];
      end
    end

    if (from_kind == K_NONE && INHIBIT)
      nxt_kind = K_PRE;
    else if (found)
      nxt_kind = K_ENTRY;
    else if (cmd_src && (from_kind == K_NONE || from_kind == K_PRE || from_kind == K_ENTRY))
      nxt_kind = K_CMD;
    else if (INHIBIT && from_kind != K_POST)
      nxt_kind = K_POST;
    else
      nxt_kind = K_NONE;
    go = (nxt_kind != K_NONE);

    sel_addr  = '0;
    sel_data  = '0;
    sel_index = '0;
    unique case (nxt_kind)
      K_ENTRY: begin
        sel_addr  = ent_addr;
        sel_data  = ent_data;
        sel_index = found_idx[3:0];
      end
      K_CMD: begin
        sel_addr  = cmd_addr;
        sel_data  = cmd_data;
        sel_index = 4'(NUM_REGS);
      end
      K_PRE: begin
        sel_addr  = DATA_WIDTH'(8'h0B);
        sel_data  = DATA_WIDTH'(8'h82);
        sel_index = 4'hF;
      end
      K_POST: begin
        sel_addr  = DATA_WIDTH'(8'h0B);
        sel_data  = DATA_WIDTH'(8'h02);
        sel_index = 4'hF;
      end
      default: sel_index = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      S_IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = go ? S_ADDR : S_FIN;
      end
      S_ADDR:  if (tc) state_d = S_LATCH;
      S_LATCH: state_d = S_GAP;
      S_GAP:   if (tc) state_d = S_WRITE;
      S_WRITE: if (tc) state_d = S_REC;
      S_REC: if (tc) begin
        load    = 1'b1;
        state_d = go ? S_ADDR : S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state || state == S_IDLE) cnt_d = '0;
    else if (tc)                             cnt_d = cnt;
    else                                     cnt_d = cnt + CNT_W'(1);

    control_d = CTRL_PARK;
    ad_d      = '0;
    unique case (state_d)
      S_ADDR: begin
        control_d = CTRL_ADDR;
        ad_d      = load ? sel_addr : addr_q;
      end
      S_LATCH: begin
        control_d = CTRL_HOLD;
        ad_d      = addr_q;
      end
      S_GAP:   control_d = CTRL_HOLD;
      S_WRITE: begin
        control_d = CTRL_WRITE;
        ad_d      = data_q;
      end
      default: control_d = CTRL_PARK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_q      <= K_NONE;
      idx_q       <= '0;
      en_q        <= '0;
      edm_q       <= '0;
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      control_q   <= CTRL_PARK;
      ad_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_index_q <= '0;
    end else begin
      control_q <= control_d;
      ad_q      <= ad_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_FIN);
      if (state == S_IDLE && bus.start) begin
        en_q  <= reg_en;
        edm_q <= edit_mask;
        cmd_q <= cmd_en;
      end
      if (load && go) begin
        kind_q      <= nxt_kind;
        idx_q       <= found_idx;
        addr_q      <= sel_addr;
        data_q      <= sel_data;
        cur_index_q <= sel_index;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_index = cur_index_q;
  assign bus.control   = control_q;
  assign bus.AD        = ad_q;

endmodule

// File: tb/tb_rtc_bus_write_sequencer.sv
// Directed bench for rtc_bus_write_sequencer; a negedge monitor logs each bus write, tasks compare against hand-built lists.
module tb_rtc_bus_write_sequencer;

`ifdef RTC_UPDATE_INHIBIT_EN
  localparam bit INH = 1'b1;
`else
  localparam bit INH = 1'b0;
`endif
  localparam int WLEN = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  reg_en, edit_mask;
  logic [71:0] addr_flat, data_flat, edit_flat;
  logic        cmd_en;
  logic [7:0]  cmd_addr, cmd_data;

  rtc_bus_write_sequencer_if #(.DATA_WIDTH(8)) bus ();

  rtc_bus_write_sequencer dut (
    .clk(clk), .reset(reset), .reg_en(reg_en), .addr_flat(addr_flat),
    .data_flat(data_flat), .edit_mask(edit_mask), .edit_flat(edit_flat),
    .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] addr_log[$], data_log[$];
  logic [3:0] idx_log[$];
  int         addr_cyc[$];
  int         done_cnt, done_cyc;
  logic [3:0] prev_ctrl = 4'b1011;
  bit         rd_low_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.control == 4'b0111 && prev_ctrl != 4'b0111) begin
      addr_log.push_back(bus.AD);
      idx_log.push_back(bus.cur_index);
      addr_cyc.push_back(cyc);
    end
    if (bus.control == 4'b0010 && prev_ctrl != 4'b0010) data_log.push_back(bus.AD);
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.control[1] !== 1'b1) rd_low_seen = 1'b1;
    prev_ctrl = bus.control;
  end

  logic [7:0] ea[$], ed[$];
  logic [3:0] ei[$];

  task automatic clear_logs();
    addr_log.delete(); data_log.delete(); idx_log.delete(); addr_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic exp_begin();
    ea.delete(); ed.delete(); ei.delete();
    if (INH) begin ea.push_back(8'h0B); ed.push_back(8'h82); ei.push_back(4'hF); end
  endtask

  task automatic exp_end();
    if (INH) begin ea.push_back(8'h0B); ed.push_back(8'h02); ei.push_back(4'hF); end
  endtask

  task automatic exp_push(input logic [7:0] a, input logic [7:0] d, input logic [3:0] i);
    ea.push_back(a); ed.push_back(d); ei.push_back(i);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.control, bus.AD, bus.busy, bus.done, bus.cur_index} !== {4'b1011, 8'h00, 1'b0, 1'b0, 4'h0}) begin
      $display("FAIL reset_state: got ctrl=%b ad=%h busy=%b done=%b idx=%h, want ctrl=1011 ad=00 busy=0 done=0 idx=0",
               bus.control, bus.AD, bus.busy, bus.done, bus.cur_index);
    end else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // 9 entries, live data: each write 23 cycles, done 9*23 cycles after the start edge.
  task automatic test_full_table();
    int s; bit ok; int n;
    reg_en = 9'h1FF; edit_mask = 9'h000; cmd_en = 1'b0;
    exp_begin();
    for (int i = 0; i < 9; i++) exp_push(8'(8'h10 + i), 8'(8'hA0 + i), 4'(i));
    exp_end();
    clear_logs();
    pulse_start(s);
    wait_idle(400, ok);
    total++;
    if (!ok) $display("FAIL full_timeout: busy still high after 400 cycles, want idle");
    else passed++;
    total++;
    if (addr_log.size() != ea.size() || data_log.size() != ea.size())
      $display("FAIL full_count: got %0d addr / %0d data writes, want %0d", addr_log.size(), data_log.size(), ea.size());
    else passed++;
    n = (addr_log.size() < ea.size()) ? addr_log.size() : ea.size();
    for (int k = 0; k < n; k++) begin
      total++;
      if ({addr_log[k], data_log[k], idx_log[k]} !== {ea[k], ed[k], ei[k]})
        $display("FAIL full_write%0d: got a=%h d=%h i=%h, want a=%h d=%h i=%h", k,
                 addr_log[k], data_log[k], idx_log[k], ea[k], ed[k], ei[k]);
      else passed++;
      if (k > 0) begin
        total++;
        if (addr_cyc[k] - addr_cyc[k-1] != WLEN)
          $display("FAIL full_spacing%0d: got %0d cycles, want %0d", k, addr_cyc[k] - addr_cyc[k-1], WLEN);
        else passed++;
      end
    end
    total++;
    if (addr_cyc.size() == 0 || addr_cyc[0] != s)
      $display("FAIL full_first_addr: got first ADDR offset %0d, want 0", (addr_cyc.size() == 0) ? -1 : addr_cyc[0] - s);
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc - s != WLEN * ea.size())
      $display("FAIL full_done: got %0d pulses at offset %0d, want 1 at %0d", done_cnt, done_cyc - s, WLEN * ea.size());
    else passed++;
  endtask

  task automatic test_edit_sparse();
    int s; bit ok;
    reg_en = 9'b000000101; edit_mask = 9'b000000100; cmd_en = 1'b0;
    edit_flat[2*8 +: 8] = 8'h59;
    exp_begin();
    exp_push(8'h10, 8'hA0, 4'h0);
    exp_push(8'h12, 8'h59, 4'h2);
    exp_end();
    clear_logs();
    pulse_start(s);
    wait_idle(200, ok);
    total++;
    if (!ok || addr_log.size() != ea.size() || data_log.size() != ea.size())
      $display("FAIL sparse_count: got ok=%0d %0d writes, want ok=1 %0d writes", ok, addr_log.size(), ea.size());
    else passed++;
    for (int k = 0; k < ea.size() && k < addr_log.size(); k++) begin
      total++;
      if ({addr_log[k], data_log[k], idx_log[k]} !== {ea[k], ed[k], ei[k]})
        $display("FAIL sparse_write%0d: got a=%h d=%h i=%h, want a=%h d=%h i=%h", k,
                 addr_log[k], data_log[k], idx_log[k], ea[k], ed[k], ei[k]);
      else passed++;
    end
    total++;
    if (done_cnt != 1 || done_cyc - s != WLEN * ea.size())
      $display("FAIL sparse_done: got %0d pulses at offset %0d, want 1 at %0d", done_cnt, done_cyc - s, WLEN * ea.size());
    else passed++;
  endtask

  task automatic test_cmd_only();
    int s; bit ok;
    reg_en = 9'h000; edit_mask = 9'h000; cmd_en = 1'b1; cmd_addr = 8'hF1; cmd_data = 8'hF1;
    exp_begin();
    exp_push(8'hF1, 8'hF1, 4'd9);
    exp_end();
    clear_logs();
    pulse_start(s);
    wait_idle(200, ok);
    total++;
    if (!ok || addr_log.size() != ea.size() || data_log.size() != ea.size())
      $display("FAIL cmd_count: got ok=%0d %0d writes, want ok=1 %0d writes", ok, addr_log.size(), ea.size());
    else passed++;
    for (int k = 0; k < ea.size() && k < addr_log.size(); k++) begin
      total++;
      if ({addr_log[k], data_log[k], idx_log[k]} !== {ea[k], ed[k], ei[k]})
        $display("FAIL cmd_write%0d: got a=%h d=%h i=%h, want a=%h d=%h i=%h", k,
                 addr_log[k], data_log[k], idx_log[k], ea[k], ed[k], ei[k]);
      else passed++;
    end
    total++;
    if (done_cnt != 1 || done_cyc - s != WLEN * ea.size())
      $display("FAIL cmd_done: got %0d pulses at offset %0d, want 1 at %0d", done_cnt, done_cyc - s, WLEN * ea.size());
    else passed++;
    cmd_en = 1'b0;
  endtask

  // Nothing enabled: FIN right after the start edge, no bus writes (wrapper writes only if built in).
  task automatic test_empty();
    int s; bit ok;
    reg_en = 9'h000; cmd_en = 1'b0;
    exp_begin();
    exp_end();
    clear_logs();
    pulse_start(s);
    wait_idle(100, ok);
    total++;
    if (!ok || addr_log.size() != ea.size())
      $display("FAIL empty_count: got ok=%0d %0d writes, want ok=1 %0d writes", ok, addr_log.size(), ea.size());
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc - s != WLEN * ea.size())
      $display("FAIL empty_done: got %0d pulses at offset %0d, want 1 at %0d", done_cnt, done_cyc - s, WLEN * ea.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    int s, s2; bit ok; int nexp;
    reg_en = 9'h1FF; edit_mask = 9'h000; cmd_en = 1'b0;
    nexp = INH ? 11 : 9;
    clear_logs();
    pulse_start(s);
    repeat (38) @(posedge clk);
    pulse_start(s2);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got busy=%b at re-start, want 1", bus.busy);
    else passed++;
    wait_idle(400, ok);
    total++;
    if (!ok || addr_log.size() != nexp)
      $display("FAIL b2b_count: got ok=%0d %0d writes, want ok=1 %0d writes", ok, addr_log.size(), nexp);
    else passed++;
    total++;
    if (done_cnt != 1 || done_cyc - s != WLEN * nexp)
      $display("FAIL b2b_done: got %0d pulses at offset %0d, want 1 at %0d", done_cnt, done_cyc - s, WLEN * nexp);
    else passed++;
    repeat (30) @(negedge clk);
    total++;
    if (done_cnt != 1 || bus.busy !== 1'b0)
      $display("FAIL b2b_no_rerun: got %0d pulses busy=%b, want 1 pulse busy=0", done_cnt, bus.busy);
    else passed++;
  endtask

  task automatic test_single_entry();
    int s; bit ok;
    reg_en = 9'h001; edit_mask = 9'h000; cmd_en = 1'b0;
    exp_begin();
    exp_push(8'h10, 8'hA0, 4'h0);
    exp_end();
    clear_logs();
    pulse_start(s);
    wait_idle(200, ok);
    total++;
    if (!ok || addr_log.size() != ea.size() || data_log.size() != ea.size())
      $display("FAIL single_count: got ok=%0d %0d writes, want ok=1 %0d writes", ok, addr_log.size(), ea.size());
    else passed++;
    for (int k = 0; k < ea.size() && k < addr_log.size(); k++) begin
      total++;
      if ({addr_log[k], data_log[k], idx_log[k]} !== {ea[k], ed[k], ei[k]})
        $display("FAIL single_write%0d: got a=%h d=%h i=%h, want a=%h d=%h i=%h", k,
                 addr_log[k], data_log[k], idx_log[k], ea[k], ed[k], ei[k]);
      else passed++;
    end
    total++;
    if (done_cnt != 1) $display("FAIL single_done: got %0d pulses, want 1", done_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    int s; bit seen;
    reg_en = 9'h1FF; edit_mask = 9'h000; cmd_en = 1'b0;
    clear_logs();
    pulse_start(s);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.control === 4'b0010) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) $display("FAIL midrst_reach: WRITE phase not seen in 200 cycles, want WRITE");
    else passed++;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.control, bus.AD, bus.busy, bus.done} !== {4'b1011, 8'h00, 1'b0, 1'b0})
      $display("FAIL midrst_outputs: got ctrl=%b ad=%h busy=%b done=%b, want ctrl=1011 ad=00 busy=0 done=0",
               bus.control, bus.AD, bus.busy, bus.done);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    repeat (60) @(negedge clk);
    total++;
    if (addr_log.size() != 0 || bus.busy !== 1'b0 || done_cnt != 0)
      $display("FAIL midrst_no_resume: got %0d writes busy=%b done=%0d, want 0 writes busy=0 done=0",
               addr_log.size(), bus.busy, done_cnt);
    else passed++;
  endtask

  task automatic test_rd_held();
    total++;
    if (rd_low_seen) $display("FAIL rd_held: got RD_n low at some point, want always 1");
    else passed++;
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    reg_en = '0; edit_mask = '0; cmd_en = 1'b0; cmd_addr = '0; cmd_data = '0;
    for (int i = 0; i < 9; i++) begin
      addr_flat[i*8 +: 8] = 8'(8'h10 + i);
      data_flat[i*8 +: 8] = 8'(8'hA0 + i);
      edit_flat[i*8 +: 8] = 8'(8'h50 + i);
    end
    done_cnt = 0;
    done_cyc = -1;

    test_reset();
    test_full_table();
    test_edit_sparse();
    test_cmd_only();
    test_empty();
    test_back_to_back();
    test_single_entry();
    test_reset_mid_write();
    test_rd_held();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
